note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//   Melody player that drives the PWM tone stage. Reads note words from an external
//   synchronous song ROM, converts pitch codes to a 12-bit period / high-time pair and
//   holds each note for its programmed number of beats, inserting an optional silent gap.
//   Outputs connect directly to the period/h_time inputs of the PWM tone generator.
// PARAMETERS
//   ADDR_W       4     song ROM address width; song holds up to 2**ADDR_W entries
//   TICK_CYCLES  1000  clk cycles per beat (1..65535)
//   GAP_TICKS    1     silent beats inserted after every note (0 = legato, max 15)
//   LOOP         0     1 = restart from address 0 at end of song instead of finishing
// PORTS
//   clk        in   1       system clock
//   rst_n      in   1       synchronous reset, active-low
//   start      in   1       level-sampled; begins playback from address 0 when idle
//   stop       in   1       abort playback, silence outputs
//   song_addr  out  ADDR_W  ROM address (registered)
//   song_data  in   8       ROM word, valid 1 cycle after song_addr: [7:4]=pitch, [3:0]=beats
//   period     out  12      tone period to PWM stage (0 = silence)
//   h_time     out  12      tone high time to PWM stage (0 = silence)
//   busy       out  1       1 in any state other than IDLE
//   done       out  1       1-cycle pulse when a non-looping song ends
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state IDLE, song_addr=0, period=0, h_time=0, busy=0, done=0,
//     beat/tick/gap counters=0. Reset mid-song aborts immediately; no done pulse.
//   Pitch map (period; h_time = period>>1): 1:3820 2:3401 3:3032 4:2862 5:2549 6:2271
//     7:2023 8:1909 (C4..C5 at 1 MHz PWM clock); codes 0 and 9..15 = rest (period=h_time=0).
//   beats==0 is the end-of-song marker; pitch field ignored for that word.
//   States: IDLE -> FETCH -> LOAD -> PLAY -> [GAP] -> FETCH ... -> DONE -> IDLE.
//   IDLE: start=1 -> song_addr<=0, FETCH. start while busy is ignored.
//   FETCH: one wait cycle for ROM latency -> LOAD.
//   LOAD: sample song_data. beats!=0: period/h_time <= mapped values, beat_cnt<=beats,
//     tick_cnt<=0 -> PLAY. beats==0: LOOP=1 -> song_addr<=0, FETCH; LOOP=0 -> DONE.
//   PLAY: tick_cnt counts 0..TICK_CYCLES-1 and wraps; each wrap decrements beat_cnt. On the
//     wrap that takes beat_cnt to 0: GAP_TICKS>0 -> period/h_time<=0, GAP; else advance.
//     Note therefore lasts exactly beats*TICK_CYCLES cycles in PLAY.
//   GAP: outputs 0 for exactly GAP_TICKS*TICK_CYCLES cycles, then advance.
//   Advance: song_addr==2**ADDR_W-1 is treated as end of song (as beats==0, no read);
//     otherwise song_addr<=song_addr+1, FETCH.
//   period/h_time hold their last value through FETCH/LOAD (no glitch between legato notes).
//   DONE: done=1 for this single cycle, period/h_time=0, -> IDLE (song_addr<=0).
//   stop=1: from any state next state IDLE, period/h_time<=0, song_addr<=0, no done pulse;
//     stop has priority over start when both asserted in IDLE (stays IDLE).
//   Latency: start sampled at edge N -> FETCH at N+1, LOAD at N+2, new period visible after N+3.
//   Per-note overhead: 2 cycles (FETCH+LOAD) in addition to PLAY/GAP time.
// TESTING (bench: ADDR_W=2, TICK_CYCLES=4, GAP_TICKS=1, LOOP=0 unless noted)
//   ROM {0x12,0x61,0x00,..}, pulse start -> period=3820,h_time=1910 for 8 cycles, 0 for 4,
//     then 2271/1135 for 4, 0 for 4, end marker -> done pulse, busy=0, outputs 0.
//   Same ROM, GAP_TICKS=0 -> 3820 held through FETCH/LOAD, 2271 starts 10 cycles after first note.
//   ROM all 4 entries 0x51 (no marker) -> 4 notes of 2549 then done after address 3.
//   LOOP=1, ROM {0x81,0x00} -> 1909 repeats indefinitely, done never asserts, busy stays 1.
//   stop asserted mid-PLAY -> next cycle period=h_time=0, busy=0, song_addr=0, no done;
//     rst_n=0 mid-GAP -> same reset values on next edge.
//   ROM {0x01,0xF2,0x00} -> rest codes give period=0 for 4 and 8 cycles; start while busy ignored.

Source files
------------

// File: rtl/note_sequencer.sv
// Melody player: fetches note words from a synchronous song ROM and drives period/h_time of the PWM tone stage.
// New note visible two cycles after playback starts (FETCH+LOAD); stop/rst_n abort at the next edge.
module note_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int TICK_CYCLES = 1000,
  parameter int GAP_TICKS   = 1,
  parameter bit LOOP        = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] song_addr,
  input  logic [7:0]        song_data,
  output logic [11:0]       period,
  output logic [11:0]       h_time,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [15:0]       TICK_LAST = 16'(TICK_CYCLES - 1);
  localparam logic [3:0]        GAP_BEATS = 4'(GAP_TICKS);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [11:0]       period_q, period_nxt;
  logic [11:0]       h_time_q, h_time_nxt;
  logic [3:0]        beat_cnt, beat_nxt;
  logic [3:0]        gap_cnt, gap_nxt;
  logic [15:0]       tick_cnt, tick_nxt;
  logic              tick_wrap;
  logic              advance;
  logic [11:0]       mapped;

  // C4..C5 periods at a 1 MHz PWM clock; unused codes are rests.
  function automatic logic [11:0] pitch_period(input logic [3:0] pitch);
    case (pitch)
      4'd1:    pitch_period = 12'd3820;
      4'd2:    pitch_period = 12'd3401;
      4'd3:    pitch_period = 12'd3032;
      4'd4:    pitch_period = 12'd2862;
      4'd5:    pitch_period = 12'd2549;
      4'd6:    pitch_period = 12'd2271;
      4'd7:    pitch_period = 12'd2023;
      4'd8:    pitch_period = 12'd1909;
      default: pitch_period = 12'd0;
    endcase
  endfunction

  assign mapped    = pitch_period(song_data[7:4]);
  assign tick_wrap = (tick_cnt == TICK_LAST);

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    period_nxt = period_q;
    h_time_nxt = h_time_q;
    beat_nxt   = beat_cnt;
    gap_nxt    = gap_cnt;
    tick_nxt   = tick_cnt;
    advance    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          addr_nxt  = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        if (song_data[3:0] != 4'd0) begin
          period_nxt = mapped;
          h_time_nxt = {1'b0, mapped[11:1]};
          beat_nxt   = song_data[3:0];
          tick_nxt   = '0;
          state_nxt  = S_PLAY;
        end else if (LOOP) begin
          addr_nxt  = '0;
          state_nxt = S_FETCH;
        end else begin
          period_nxt = '0;
          h_time_nxt = '0;
          state_nxt  = S_DONE;
        end
      end
      S_PLAY: begin
        tick_nxt = tick_wrap ? 16'd0 : tick_cnt + 16'd1;
        if (tick_wrap) begin
          beat_nxt = beat_cnt - 4'd1;
          if (beat_cnt == 4'd1) begin
            if (GAP_TICKS > 0) begin
              period_nxt = '0;
              h_time_nxt = '0;
              gap_nxt    = GAP_BEATS;
              state_nxt  = S_GAP;
            end else begin
              advance = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        tick_nxt = tick_wrap ? 16'd0 : tick_cnt + 16'd1;
        if (tick_wrap) begin
          gap_nxt = gap_cnt - 4'd1;
          if (gap_cnt == 4'd1) advance = 1'b1;
        end
      end
      S_DONE: begin
        period_nxt = '0;
        h_time_nxt = '0;
        addr_nxt   = '0;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Running off the last ROM address behaves exactly like an end marker.
    if (advance) begin
      if (addr_q == LAST_ADDR) begin
        if (LOOP) begin
          addr_nxt  = '0;
          state_nxt = S_FETCH;
        end else begin
          period_nxt = '0;
          h_time_nxt = '0;
          state_nxt  = S_DONE;
        end
      end else begin
        addr_nxt  = addr_q + 1'b1;
        state_nxt = S_FETCH;
      end
    end

    if (stop) begin
      state_nxt  = S_IDLE;
      addr_nxt   = '0;
      period_nxt = '0;
      h_time_nxt = '0;
      beat_nxt   = '0;
      gap_nxt    = '0;
      tick_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      period_q <= '0;
      h_time_q <= '0;
      beat_cnt <= '0;
      gap_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_nxt;
      period_q <= period_nxt;
      h_time_q <= h_time_nxt;
      beat_cnt <= beat_nxt;
      gap_cnt  <= gap_nxt;
      tick_cnt <= tick_nxt;
    end
  end

  assign song_addr = addr_q;
  assign period    = period_q;
  assign h_time    = h_time_q;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: three instances (gap, legato, looping) against a per-cycle trace model built from the ROM.
module tb_note_sequencer;

  localparam int T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start [3];
  logic       stop  [3];
  logic [7:0] rom   [3][4];

  logic [1:0]  addr_0, addr_1, addr_2;
  logic [7:0]  sd_0, sd_1, sd_2;
  logic [11:0] per_0, per_1, per_2;
  logic [11:0] ht_0, ht_1, ht_2;
  logic        busy_0, busy_1, busy_2;
  logic        done_0, done_1, done_2;

  logic [11:0] obs_per  [3];
  logic [11:0] obs_ht   [3];
  logic [1:0]  obs_addr [3];
  logic        obs_busy [3];
  logic        obs_done [3];

  note_sequencer #(.ADDR_W(2), .TICK_CYCLES(T), .GAP_TICKS(1), .LOOP(1'b0)) dut_gap (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .stop(stop[0]), .song_addr(addr_0),
    .song_data(sd_0), .period(per_0), .h_time(ht_0), .busy(busy_0), .done(done_0));
  note_sequencer #(.ADDR_W(2), .TICK_CYCLES(T), .GAP_TICKS(0), .LOOP(1'b0)) dut_legato (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .stop(stop[1]), .song_addr(addr_1),
    .song_data(sd_1), .period(per_1), .h_time(ht_1), .busy(busy_1), .done(done_1));
  note_sequencer #(.ADDR_W(2), .TICK_CYCLES(T), .GAP_TICKS(1), .LOOP(1'b1)) dut_loop (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .stop(stop[2]), .song_addr(addr_2),
    .song_data(sd_2), .period(per_2), .h_time(ht_2), .busy(busy_2), .done(done_2));

  // Synchronous song ROMs: word appears one cycle after the address.
  always @(posedge clk) begin
    sd_0 <= rom[0][addr_0];
    sd_1 <= rom[1][addr_1];
    sd_2 <= rom[2][addr_2];
  end

  always_comb begin
    obs_per[0] = per_0;  obs_per[1] = per_1;  obs_per[2] = per_2;
    obs_ht[0]  = ht_0;   obs_ht[1]  = ht_1;   obs_ht[2]  = ht_2;
    obs_addr[0] = addr_0; obs_addr[1] = addr_1; obs_addr[2] = addr_2;
    obs_busy[0] = busy_0; obs_busy[1] = busy_1; obs_busy[2] = busy_2;
    obs_done[0] = done_0; obs_done[1] = done_1; obs_done[2] = done_2;
  end

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pitch_ref(input int code);
    case (code)
      1: return 3820;
      2: return 3401;
      3: return 3032;
      4: return 2862;
      5: return 2549;
      6: return 2271;
      7: return 2023;
      8: return 1909;
      default: return 0;
    endcase
  endfunction

  // Expected per-cycle outputs after the start edge.
  int qp[$];
  bit qb[$];
  bit qd[$];

  function automatic void push(input int p, input bit b, input bit d);
    qp.push_back(p);
    qb.push_back(b);
    qd.push_back(d);
  endfunction

  task automatic build(input int k, input int gap, input bit loop, input int cap);
    int cur;
    int addr;
    int w;
    int beats;
    int p;
    cur = 0;
    addr = 0;
    qp.delete(); qb.delete(); qd.delete();
    while (qp.size() < cap) begin
      push(cur, 1, 0);
      push(cur, 1, 0);
      w = int'(rom[k][addr]);
      beats = w % 16;
      if (beats == 0) begin
        if (loop) begin
          addr = 0;
          continue;
        end
        push(0, 1, 1);
        push(0, 0, 0);
        break;
      end
      p = pitch_ref(w / 16);
      repeat (beats * T) push(p, 1, 0);
      cur = p;
      if (gap > 0) begin
        repeat (gap * T) push(0, 1, 0);
        cur = 0;
      end
      if (addr == 3) begin
        if (loop) begin
          addr = 0;
          continue;
        end
        push(0, 1, 1);
        push(0, 0, 0);
        break;
      end
      addr++;
    end
    while (qp.size() > cap) begin
      void'(qp.pop_back());
      void'(qb.pop_back());
      void'(qd.pop_back());
    end
  endtask

  task automatic play(input int k, input int cap, input bit poke);
    build(k, (k == 1) ? 0 : 1, (k == 2), cap);
    @(negedge clk);
    start[k] = 1'b1;
    for (int i = 0; i < qp.size(); i++) begin
      @(negedge clk);
      start[k] = 1'b0;
      chk($sformatf("period[%0d] c%0d", k, i), 32'(obs_per[k]), 32'(qp[i]));
      chk($sformatf("h_time[%0d] c%0d", k, i), 32'(obs_ht[k]), 32'(qp[i] / 2));
      chk($sformatf("busy[%0d] c%0d", k, i), 32'(obs_busy[k]), 32'(qb[i]));
      chk($sformatf("done[%0d] c%0d", k, i), 32'(obs_done[k]), 32'(qd[i]));
      // start while busy must be ignored
      if (poke && qb[i] && $urandom_range(0, 2) == 0) start[k] = 1'b1;
    end
    start[k] = 1'b0;
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk({tag, " period"}, 32'(obs_per[k]), 32'd0);
    chk({tag, " h_time"}, 32'(obs_ht[k]), 32'd0);
    chk({tag, " busy"}, 32'(obs_busy[k]), 32'd0);
    chk({tag, " done"}, 32'(obs_done[k]), 32'd0);
    chk({tag, " addr"}, 32'(obs_addr[k]), 32'd0);
  endtask

  task automatic load_rom(input int k, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input logic [7:0] w3);
    rom[k][0] = w0; rom[k][1] = w1; rom[k][2] = w2; rom[k][3] = w3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      stop[k]  = 1'b0;
      load_rom(k, 8'h00, 8'h00, 8'h00, 8'h00);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_idle(k, $sformatf("reset[%0d]", k));
    rst_n = 1'b1;
    @(negedge clk);

    // two notes with silent gaps, then end marker
    load_rom(0, 8'h12, 8'h61, 8'h00, 8'h00);
    play(0, 500, 1'b0);
    // legato: first note held through FETCH/LOAD of the second
    load_rom(1, 8'h12, 8'h61, 8'h00, 8'h00);
    play(1, 500, 1'b0);
    // no marker: song ends after the last address
    load_rom(0, 8'h51, 8'h51, 8'h51, 8'h51);
    play(0, 500, 1'b0);
    load_rom(1, 8'h51, 8'h51, 8'h51, 8'h51);
    play(1, 500, 1'b0);
    // looping song never finishes; stop it afterwards
    load_rom(2, 8'h81, 8'h00, 8'h00, 8'h00);
    play(2, 80, 1'b0);
    @(negedge clk);
    stop[2] = 1'b1;
    @(negedge clk);
    stop[2] = 1'b0;
    chk_idle(2, "loop stop");
    // rest codes
    load_rom(0, 8'h01, 8'hF2, 8'h00, 8'h00);
    play(0, 500, 1'b1);

    // stop mid-PLAY
    load_rom(0, 8'h12, 8'h61, 8'h00, 8'h00);
    @(negedge clk);
    start[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    chk("pre-stop period", 32'(obs_per[0]), 32'd3820);
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    chk_idle(0, "stop");
    repeat (6) begin
      @(negedge clk);
      chk("post-stop done", 32'(obs_done[0]), 32'd0);
    end

    // reset in the gap after the second note
    @(negedge clk);
    start[0] = 1'b1;
    repeat (22) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    chk("pre-reset addr", 32'(obs_addr[0]), 32'd1);
    chk("pre-reset busy", 32'(obs_busy[0]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle(0, "midgap reset");

    // stop wins over start in IDLE
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    stop[0]  = 1'b0;
    chk_idle(0, "stop+start");
    @(negedge clk);
    chk("stop+start busy2", 32'(obs_busy[0]), 32'd0);

    // randomized songs on the gap and legato players
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 4; j++)
          rom[k][j] = 8'(($urandom_range(0, 15) << 4) | $urandom_range(0, 3));
        play(k, 500, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
